host_cmd_decoder: RTL and testbench
===================================

Name: host_cmd_decoder

Overview:
- Host-side command engine that drives the register block's one-hot write/read strobe bus (WE_BIT/RE_BIT, DATA, RD).
- Parses a byte stream from the UART receiver into register writes and reads.
- Returns one response byte per command to the UART transmitter through a valid/ready handshake.
- Sits between the UART RX/TX pair and the eye-tracker register block.

Parameters:
- DATA_WIDTH, 8, byte width of the register data bus and the UART data.
- WE_WIDTH, 24, number of one-hot write strobes (valid write addresses 0..WE_WIDTH-1).
- RE_WIDTH, 24, number of one-hot read strobes (valid read addresses 0..RE_WIDTH-1).
- TIMEOUT_CYCLES, 1000000, maximum cycles to wait for a write's data byte.
- ACK_BYTE, 8'h06, response byte for a successful write.
- NAK_BYTE, 8'h15, response byte for an invalid address.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous active-high reset.
- iRX_VALID  input  1  one-cycle pulse; iRX_DATA holds a received byte.
- iRX_DATA  input  DATA_WIDTH  received byte.
- oTX_VALID  output  1  response byte valid.
- oTX_DATA  output  DATA_WIDTH  response byte.
- iTX_READY  input  1  transmitter accepts the byte when oTX_VALID and iTX_READY are both 1.
- oWE_BIT  output  WE_WIDTH  one-hot write strobe to the register block.
- oRE_BIT  output  RE_WIDTH  one-hot read select to the register block.
- oDATA  output  DATA_WIDTH  write data to the register block.
- iRD  input  DATA_WIDTH  combinational read data from the register block.
- oBUSY  output  1  1 whenever the state is not IDLE.
- oTIMEOUT  output  1  one-cycle pulse when a write is aborted by timeout.
- oOVERRUN  output  1  sticky flag: a byte was dropped; cleared only by RST.

Behaviour:
- Single clock, CLK. Reset is synchronous and active-high on RST. All state is registered.
- On reset:
  - state goes to IDLE.
  - oWE_BIT, oRE_BIT, oDATA, oTX_VALID, oTX_DATA, oTIMEOUT and oOVERRUN all go to 0.
  - the timeout counter goes to 0.
- Reset asserted mid-command aborts the command. No strobe fires after reset, and any pending TX byte is discarded.
- Command byte format:
  - bit7 = 1 means write, 0 means read.
  - bits[6:0] = address.
  - A write is followed by exactly one data byte. A read has no further bytes.
- States: IDLE, WAIT_DATA, WRITE, READ, TX.
- IDLE, on iRX_VALID:
  - Write command: latch address and validity, go to WAIT_DATA, clear the counter.
  - Read command with address < RE_WIDTH: go to READ.
  - Read command with address >= RE_WIDTH: load NAK_BYTE, go to TX.
- WAIT_DATA:
  - On iRX_VALID: latch the data byte.
    - Address valid: go to WRITE.
    - Address invalid (>= WE_WIDTH): load NAK_BYTE, go to TX. The data byte is consumed; no strobe is issued.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no byte: pulse oTIMEOUT, go to IDLE, send no response.
  - iRX_VALID on the final counter cycle takes priority over the timeout.
- WRITE (exactly 1 cycle):
  - oWE_BIT has a single bit set at the address; oDATA = latched data.
  - Load ACK_BYTE, go to TX.
- READ (exactly 1 cycle):
  - oRE_BIT has a single bit set at the address.
  - iRD is captured into oTX_DATA at the end of this cycle. Go to TX.
- TX:
  - oTX_VALID = 1 and oTX_DATA is held stable until the cycle where iTX_READY = 1. That cycle is the transfer; go to IDLE next cycle with oTX_VALID = 0.
  - oTX_VALID never deasserts without a transfer.
- Strobe timing:
  - oWE_BIT and oRE_BIT are 0 in every state except WRITE and READ respectively.
  - At most one bit is ever set, and never both buses at once.
  - oDATA is 0 outside WRITE.
- Latency:
  - Read: command byte at cycle N, RE strobe at N+1, oTX_VALID at N+2.
  - Write: data byte at cycle M, WE strobe at M+1, oTX_VALID at M+2.
- Dropped bytes: iRX_VALID in WRITE, READ or TX is dropped and sets oOVERRUN. The byte is not queued.
- Address compare uses all 7 address bits. No wrap-around: addresses 24..127 are invalid.

Test Plan:
- Write threshold: RX 0x82 then 0x40 -> oWE_BIT = 24'h000004 for 1 cycle with oDATA = 0x40, then oTX_DATA = 0x06.
- Read: RX 0x14 with iRD = 0x5A while oRE_BIT = 24'h100000 -> oTX_DATA = 0x5A at N+2.
- Invalid addresses:
  - RX 0x1F (read, address 31) -> no RE strobe, TX 0x15.
  - RX 0x9F then 0x77 -> no WE strobe, TX 0x15.
- Timeout: TIMEOUT_CYCLES = 16, RX 0x81 then nothing:
  - oTIMEOUT pulses once; state returns to IDLE; no TX byte.
  - A following read 0x00 then works normally.
- TX backpressure plus overrun:
  - Hold iTX_READY = 0 for 10 cycles after a read; oTX_VALID and oTX_DATA stay stable throughout.
  - Inject iRX_VALID during that window -> byte dropped, oOVERRUN = 1.
- Reset: assert RST in WAIT_DATA, then send the data byte -> no WE strobe; all outputs 0 one cycle after RST.

Source files
------------

// File: rtl/host_cmd_decoder.sv
// Host command engine: turns UART RX bytes into one-hot register write/read strobes
// and returns one response byte per command over a valid/ready handshake.
module host_cmd_decoder #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    WE_WIDTH       = 24,
    parameter int                    RE_WIDTH       = 24,
    parameter int                    TIMEOUT_CYCLES = 1000000,
    parameter logic [DATA_WIDTH-1:0] ACK_BYTE       = 8'h06,
    parameter logic [DATA_WIDTH-1:0] NAK_BYTE       = 8'h15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iRX_VALID,
    input  logic [DATA_WIDTH-1:0] iRX_DATA,
    output logic                  oTX_VALID,
    output logic [DATA_WIDTH-1:0] oTX_DATA,
    input  logic                  iTX_READY,
    output logic [WE_WIDTH-1:0]   oWE_BIT,
    output logic [RE_WIDTH-1:0]   oRE_BIT,
    output logic [DATA_WIDTH-1:0] oDATA,
    input  logic [DATA_WIDTH-1:0] iRD,
    output logic                  oBUSY,
    output logic                  oTIMEOUT,
    output logic                  oOVERRUN
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        WRITE,
        READ,
        TX
    } state_t;

    state_t                  r_state;
    logic [6:0]              r_addr;
    logic                    r_wr_ok;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_tx_valid;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic [WE_WIDTH-1:0]     r_we;
    logic [RE_WIDTH-1:0]     r_re;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_timeout;
    logic                    r_overrun;

    logic                    w_is_write;
    logic [6:0]              w_rx_addr;
    logic                    w_rd_ok;
    logic                    w_wr_ok;

    assign w_is_write = iRX_DATA[DATA_WIDTH-1];
    assign w_rx_addr  = iRX_DATA[6:0];
    // Full 7-bit compare: addresses beyond the strobe width never alias onto low strobes.
    assign w_rd_ok    = (32'(w_rx_addr) < RE_WIDTH);
    assign w_wr_ok    = (32'(w_rx_addr) < WE_WIDTH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wr_ok    <= 1'b0;
            r_cnt      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_we       <= '0;
            r_re       <= '0;
            r_data     <= '0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iRX_VALID) begin
                        if (w_is_write) begin
                            r_addr  <= w_rx_addr;
                            r_wr_ok <= w_wr_ok;
                            r_cnt   <= '0;
                            r_state <= WAIT_DATA;
                        end else if (w_rd_ok) begin
                            r_re    <= RE_WIDTH'(1) << w_rx_addr;
                            r_state <= READ;
                        end else begin
                            r_tx_data  <= NAK_BYTE;
                            r_tx_valid <= 1'b1;
                            r_state    <= TX;
                        end
                    end
                end
                WAIT_DATA: begin
                    // A byte arriving on the last counter cycle still wins over the timeout.
                    if (iRX_VALID) begin
                        if (r_wr_ok) begin
                            r_we    <= WE_WIDTH'(1) << r_addr;
                            r_data  <= iRX_DATA;
                            r_state <= WRITE;
                        end else begin
                            r_tx_data  <= NAK_BYTE;
                            r_tx_valid <= 1'b1;
                            r_state    <= TX;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    r_we       <= '0;
                    r_data     <= '0;
                    r_tx_data  <= ACK_BYTE;
                    r_tx_valid <= 1'b1;
                    r_state    <= TX;
                end
                READ: begin
                    r_re       <= '0;
                    r_tx_data  <= iRD;
                    r_tx_valid <= 1'b1;
                    r_state    <= TX;
                end
                TX: begin
                    if (iTX_READY) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (iRX_VALID && (r_state == WRITE || r_state == READ || r_state == TX)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign oTX_VALID = r_tx_valid;
    assign oTX_DATA  = r_tx_data;
    assign oWE_BIT   = r_we;
    assign oRE_BIT   = r_re;
    assign oDATA     = r_data;
    assign oBUSY     = (r_state != IDLE);
    assign oTIMEOUT  = r_timeout;
    assign oOVERRUN  = r_overrun;

endmodule

// File: tb/tb_host_cmd_decoder.sv
// Directed bench for host_cmd_decoder; response bytes are checked against a queue
// of expected values filled as each command is driven.
module tb_host_cmd_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iRX_VALID = 1'b0;
    logic [7:0]  iRX_DATA = '0;
    logic        oTX_VALID;
    logic [7:0]  oTX_DATA;
    logic        iTX_READY = 1'b1;
    logic [23:0] oWE_BIT;
    logic [23:0] oRE_BIT;
    logic [7:0]  oDATA;
    logic [7:0]  iRD;
    logic        oBUSY;
    logic        oTIMEOUT;
    logic        oOVERRUN;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rd_mem[24];
    int          to_pulses;
    int          tx_seen;

    host_cmd_decoder #(
        .DATA_WIDTH(8), .WE_WIDTH(24), .RE_WIDTH(24),
        .TIMEOUT_CYCLES(16), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
    ) dut (
        .CLK(CLK), .RST(RST),
        .iRX_VALID(iRX_VALID), .iRX_DATA(iRX_DATA),
        .oTX_VALID(oTX_VALID), .oTX_DATA(oTX_DATA), .iTX_READY(iTX_READY),
        .oWE_BIT(oWE_BIT), .oRE_BIT(oRE_BIT), .oDATA(oDATA), .iRD(iRD),
        .oBUSY(oBUSY), .oTIMEOUT(oTIMEOUT), .oOVERRUN(oOVERRUN)
    );

    always #5 CLK = ~CLK;

    // Register block model: combinational read data selected by the one-hot strobe.
    always_comb begin
        iRD = 8'h00;
        for (int i = 0; i < 24; i++) begin
            if (oRE_BIT[i]) iRD = rd_mem[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed TX transfer pops one expected response byte.
    always @(negedge CLK) begin
        if (oTX_VALID && iTX_READY) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected", 32'(oTX_DATA), 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", 32'(oTX_DATA), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one byte for exactly one cycle; returns #1 after the edge that sampled it.
    task automatic send_byte(input logic [7:0] b);
        tick();
        iRX_VALID = 1'b1;
        iRX_DATA  = b;
        tick();
        iRX_VALID = 1'b0;
        iRX_DATA  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},   32'(oWE_BIT),   32'h0);
        check({tag, "_re"},   32'(oRE_BIT),   32'h0);
        check({tag, "_data"}, 32'(oDATA),     32'h0);
        check({tag, "_txv"},  32'(oTX_VALID), 32'h0);
        check({tag, "_txd"},  32'(oTX_DATA),  32'h0);
        check({tag, "_to"},   32'(oTIMEOUT),  32'h0);
        check({tag, "_ovr"},  32'(oOVERRUN),  32'h0);
        check({tag, "_busy"}, 32'(oBUSY),     32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 24; i++) rd_mem[i] = 8'(8'hA0 + i);
        rd_mem[20] = 8'h5A;
        rd_mem[0]  = 8'h3C;

        // Reset
        repeat (3) tick();
        RST = 1'b0;
        check_all_zero("reset");

        // Write address 2 with 0x40
        exp_q.push_back(8'h06);
        send_byte(8'h82);
        check("wr_busy", 32'(oBUSY), 32'h1);
        check("wr_wait_we", 32'(oWE_BIT), 32'h0);
        send_byte(8'h40);
        check("wr_strobe", 32'(oWE_BIT), 32'h000004);
        check("wr_odata", 32'(oDATA), 32'h40);
        tick();
        check("wr_strobe_off", 32'(oWE_BIT), 32'h0);
        check("wr_odata_off", 32'(oDATA), 32'h0);
        check("wr_txv", 32'(oTX_VALID), 32'h1);
        tick();
        check("wr_txv_off", 32'(oTX_VALID), 32'h0);
        check("wr_idle", 32'(oBUSY), 32'h0);

        // Read address 20
        exp_q.push_back(8'h5A);
        send_byte(8'h14);
        check("rd_strobe", 32'(oRE_BIT), 32'h100000);
        check("rd_no_we", 32'(oWE_BIT), 32'h0);
        tick();
        check("rd_strobe_off", 32'(oRE_BIT), 32'h0);
        check("rd_txv", 32'(oTX_VALID), 32'h1);
        check("rd_txd", 32'(oTX_DATA), 32'h5A);
        tick();

        // Invalid read address 31
        exp_q.push_back(8'h15);
        send_byte(8'h1F);
        check("badrd_re", 32'(oRE_BIT), 32'h0);
        check("badrd_txv", 32'(oTX_VALID), 32'h1);
        tick();

        // Invalid write address 31
        exp_q.push_back(8'h15);
        send_byte(8'h9F);
        send_byte(8'h77);
        check("badwr_we", 32'(oWE_BIT), 32'h0);
        check("badwr_txv", 32'(oTX_VALID), 32'h1);
        tick();

        // Timeout on write with no data byte
        send_byte(8'h81);
        to_pulses = 0;
        tx_seen   = 0;
        for (int i = 0; i < 30; i++) begin
            if (oTIMEOUT) to_pulses++;
            if (oTX_VALID) tx_seen++;
            if (oWE_BIT != 24'h0) tx_seen++;
            tick();
        end
        check("to_pulses", 32'(to_pulses), 32'h1);
        check("to_no_tx", 32'(tx_seen), 32'h0);
        check("to_idle", 32'(oBUSY), 32'h0);
        exp_q.push_back(8'h3C);
        send_byte(8'h00);
        check("to_rd_strobe", 32'(oRE_BIT), 32'h000001);
        tick();
        tick();

        // Backpressure with an overrun byte injected during TX
        iTX_READY = 1'b0;
        exp_q.push_back(8'h5A);
        send_byte(8'h14);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_txv", 32'(oTX_VALID), 32'h1);
            check("bp_txd", 32'(oTX_DATA), 32'h5A);
            iRX_VALID = (i == 3);
            iRX_DATA  = (i == 3) ? 8'h55 : 8'h00;
            tick();
        end
        iRX_VALID = 1'b0;
        check("bp_overrun", 32'(oOVERRUN), 32'h1);
        iTX_READY = 1'b1;
        tick();
        check("bp_txv_off", 32'(oTX_VALID), 32'h0);
        check("bp_overrun_sticky", 32'(oOVERRUN), 32'h1);
        tick();

        // Reset while waiting for a write data byte
        send_byte(8'h83);
        check("rst_wait_busy", 32'(oBUSY), 32'h1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_all_zero("midrst");
        exp_q.push_back(8'h15);
        send_byte(8'h40);
        check("midrst_no_we", 32'(oWE_BIT), 32'h0);
        check("midrst_nak_txv", 32'(oTX_VALID), 32'h1);
        repeat (3) tick();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
